// File: rtl/pixel_pkg.sv
// Shared constants, state encoding and address helpers for the pixel write port.
// Framebuffer is 160x120, one COLOUR_W-bit word per pixel, row-major.
package pixel_pkg;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;
  localparam int COORD_W  = 8;
  localparam int FB_WORDS = H_RES * V_RES;

  localparam logic [COORD_W-1:0] X_LIMIT   = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] Y_LIMIT   = COORD_W'(V_RES);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COLOUR_W-1:0] colour;
  } plot_t;

  // y*160 + x as two shifts and adds; exact for every in-range coordinate.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] y_w;
    logic [ADDR_W-1:0] x_w;
    y_w = ADDR_W'(y);
    x_w = ADDR_W'(x);
    return (y_w << 7) + (y_w << 5) + x_w;
  endfunction

  function automatic logic in_range(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
    return (x < X_LIMIT) && (y < Y_LIMIT);
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO holding pending plots; simultaneous push and pop allowed.
// Read data is the head entry, visible combinationally while not empty.
module plot_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_write_port.sv
// Accepts plot requests, buffers them, and drives the framebuffer write port;
// also performs a full-screen clear sweep with a latched colour.
module pixel_write_port
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COORD_W-1:0]  plot_x,
  input  logic [COORD_W-1:0]  plot_y,
  input  logic [COLOUR_W-1:0] plot_colour,
  input  logic                plot_valid,
  output logic                plot_ready,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                busy,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOUR_W-1:0] fb_data,
  output logic                fb_we,
  output logic [7:0]          drop_count
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_clear_pending;
  logic                   r_sweep_tail;
  logic [COLOUR_W-1:0]    r_clear_colour;
  logic [ADDR_W-1:0]      r_clear_addr;
  logic                   r_fb_we;
  logic [ADDR_W-1:0]      r_fb_addr;
  logic [COLOUR_W-1:0]    r_fb_data;
  logic [7:0]             r_drop_count;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [$bits(plot_t)-1:0] w_fifo_rd;
  plot_t                  w_head;
  plot_t                  w_in;
  logic                   w_clear_accept;
  logic                   w_sweep_last;

  assign w_in.x      = plot_x;
  assign w_in.y      = plot_y;
  assign w_in.colour = plot_colour;
  assign w_head      = w_fifo_rd;

  assign plot_ready     = !reset && !w_fifo_full && !r_clear_pending && (r_state != ST_CLEAR);
  assign w_push         = plot_valid && plot_ready;
  assign w_pop          = !w_fifo_empty && (r_state == ST_IDLE);
  assign w_clear_accept = clear_req && (r_state == ST_IDLE) && !r_clear_pending;
  assign w_sweep_last   = (r_state == ST_CLEAR) && (r_clear_addr == LAST_ADDR);

  plot_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(plot_t))
  ) u_plot_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data (w_in),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_rd),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The sweep waits for the last plot write to leave the output register.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_clear_pending && w_fifo_empty && !r_fb_we && !r_sweep_tail) begin
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (r_clear_addr == LAST_ADDR) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fb_we         <= 1'b0;
      r_fb_addr       <= '0;
      r_fb_data       <= '0;
      r_drop_count    <= '0;
      r_clear_addr    <= '0;
      r_clear_pending <= 1'b0;
      r_clear_colour  <= '0;
      r_sweep_tail    <= 1'b0;
    end else begin
      r_fb_we <= 1'b0;
      if (r_state == ST_CLEAR) begin
        r_fb_we      <= 1'b1;
        r_fb_addr    <= r_clear_addr;
        r_fb_data    <= r_clear_colour;
        r_clear_addr <= w_sweep_last ? '0 : r_clear_addr + ADDR_W'(1);
      end else if (w_pop) begin
        if (in_range(w_head.x, w_head.y)) begin
          r_fb_we   <= 1'b1;
          r_fb_addr <= xy_to_addr(w_head.x, w_head.y);
          r_fb_data <= w_head.colour;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end

      // Pending is held through the final sweep write so ready rises only after it.
      r_sweep_tail <= w_sweep_last;
      if (w_clear_accept) begin
        r_clear_pending <= 1'b1;
        r_clear_colour  <= clear_colour;
      end else if (r_sweep_tail) begin
        r_clear_pending <= 1'b0;
      end
    end
  end

  assign fb_we      = r_fb_we;
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;
  assign drop_count = r_drop_count;
  assign busy       = !w_fifo_empty || r_clear_pending || (r_state == ST_CLEAR) || r_fb_we;

endmodule

// File: tb/tb_pixel_write_port.sv
// Directed self-checking bench for pixel_write_port: plots, drops, clears, reset mid-sweep.
module tb_pixel_write_port;
  import pixel_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          plot_x;
  logic [7:0]          plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic                plot_valid;
  logic                plot_ready;
  logic                clear_req;
  logic [COLOUR_W-1:0] clear_colour;
  logic                busy;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_data;
  logic                fb_we;
  logic [7:0]          drop_count;

  pixel_write_port #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .plot_x       (plot_x),
    .plot_y       (plot_y),
    .plot_colour  (plot_colour),
    .plot_valid   (plot_valid),
    .plot_ready   (plot_ready),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .busy         (busy),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .fb_we        (fb_we),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      wr_addr_q.push_back(int'(fb_addr));
      wr_data_q.push_back(int'(fb_data));
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_plot(input int x, input int y, input int c,
                           input bit with_clear, input int cc, output int acc_cyc);
    bit done;
    done         = 1'b0;
    acc_cyc      = -1;
    plot_x       = 8'(x);
    plot_y       = 8'(y);
    plot_colour  = COLOUR_W'(c);
    plot_valid   = 1'b1;
    clear_req    = with_clear;
    clear_colour = COLOUR_W'(cc);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (plot_ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        done    = 1'b1;
      end
    end
    plot_valid = 1'b0;
    clear_req  = 1'b0;
    if (!done) check_eq("plot_accept_timeout", 0, 1);
    else $display("plot x=%0d y=%0d c=%0d clear=%0b accepted at cycle %0d", x, y, c, with_clear, acc_cyc);
  endtask

  // Watches a clear sweep until plot_ready rises again.
  task automatic wait_ready(output int busy_low, output int ready_cyc, output int n_wr);
    bit seen;
    seen      = 1'b0;
    busy_low  = 0;
    ready_cyc = -1;
    n_wr      = 0;
    for (int t = 0; t < 20500 && !seen; t++) begin
      @(negedge clk);
      if (plot_ready === 1'b1) begin
        seen      = 1'b1;
        ready_cyc = cyc;
        n_wr      = wr_addr_q.size();
      end else if (busy !== 1'b1) begin
        busy_low++;
      end
    end
    if (!seen) check_eq("ready_after_clear_timeout", 0, 1);
    $display("sweep finished: ready at cycle %0d after %0d writes", ready_cyc, n_wr);
  endtask

  function automatic int sweep_errors(input int base, input int colour);
    int errs;
    errs = 0;
    for (int i = 0; i < FB_WORDS; i++) begin
      if (base + i >= wr_addr_q.size()) begin
        errs++;
      end else if (wr_addr_q[base+i] != i || wr_data_q[base+i] != colour ||
                   wr_cyc_q[base+i] != wr_cyc_q[base] + i) begin
        errs++;
      end
    end
    return errs;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc0;
    int drops;
    int bad;
    int busy_low;
    int ready_cyc;
    int n_wr;
    int base;
    bit hit;

    reset        = 1'b1;
    plot_x       = '0;
    plot_y       = '0;
    plot_colour  = '0;
    plot_valid   = 1'b0;
    clear_req    = 1'b0;
    clear_colour = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("ready_during_reset", plot_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", plot_ready, 1);
    check_eq("busy_after_reset", busy, 0);
    check_eq("we_after_reset", fb_we, 0);
    check_eq("addr_after_reset", fb_addr, 0);
    check_eq("data_after_reset", fb_data, 0);
    check_eq("drop_after_reset", drop_count, 0);

    // Single plot: 2*160+5 = 325, two-cycle latency
    tick(1);
    clear_log();
    send_plot(5, 2, 5, 1'b0, 0, acc);
    tick(5);
    check_eq("single_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check_eq("single_addr", wr_addr_q[0], 325);
      check_eq("single_data", wr_data_q[0], 5);
      check_eq("single_latency", wr_cyc_q[0] - acc, 1);
    end
    check_eq("single_busy_idle", busy, 0);

    // Eight back-to-back plots on the last row: 119*160 = 19040
    clear_log();
    drops      = 0;
    plot_y     = 8'd119;
    plot_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      plot_x      = 8'(i);
      plot_colour = COLOUR_W'(i);
      @(negedge clk);
      if (plot_ready !== 1'b1) drops++;
      @(posedge clk);
      #1;
      $display("plot x=%0d y=119 c=%0d streamed at cycle %0d", i, i, cyc);
    end
    plot_valid = 1'b0;
    tick(5);
    check_eq("burst_ready_drops", drops, 0);
    check_eq("burst_count", wr_addr_q.size(), 8);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] != 19040 + i || wr_data_q[i] != i || wr_cyc_q[i] != wr_cyc_q[0] + i) bad++;
    end
    check_eq("burst_seq_errors", bad, 0);
    if (wr_addr_q.size() == 8) check_eq("burst_last_addr", wr_addr_q[7], 19047);

    // Out-of-range plots are dropped and counted
    clear_log();
    send_plot(160, 0, 1, 1'b0, 0, acc);
    send_plot(0, 120, 1, 1'b0, 0, acc);
    tick(4);
    check_eq("oor_no_write", wr_addr_q.size(), 0);
    check_eq("oor_drop_two", drop_count, 2);
    plot_x     = 8'd200;
    plot_y     = 8'd0;
    plot_valid = 1'b1;
    tick(300);
    plot_valid = 1'b0;
    tick(4);
    $display("300 out-of-range plots streamed, drop_count=%0d", drop_count);
    check_eq("oor_saturate", drop_count, 255);
    check_eq("oor_still_no_write", wr_addr_q.size(), 0);

    // Clear with plots in flight: plots first, then the full sweep
    clear_log();
    send_plot(1, 1, 7, 1'b0, 0, acc);
    send_plot(2, 1, 7, 1'b0, 0, acc);
    send_plot(3, 1, 7, 1'b1, 2, acc);
    wait_ready(busy_low, ready_cyc, n_wr);
    check_eq("clr_busy_low_cycles", busy_low, 0);
    check_eq("clr_writes_at_ready", n_wr, 3 + FB_WORDS);
    if (wr_addr_q.size() >= 3) begin
      check_eq("clr_plot0_addr", wr_addr_q[0], 161);
      check_eq("clr_plot2_addr", wr_addr_q[2], 163);
      check_eq("clr_plot2_data", wr_data_q[2], 7);
    end
    check_eq("clr_sweep_errors", sweep_errors(3, 2), 0);
    if (wr_cyc_q.size() > 0) check_eq("clr_ready_after_last", ready_cyc - wr_cyc_q[wr_cyc_q.size()-1], 1);

    // Reset in the middle of a sweep
    tick(2);
    clear_log();
    clear_req    = 1'b1;
    clear_colour = 3'd1;
    tick(1);
    clear_req = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 6000 && !hit; t++) begin
      @(negedge clk);
      if (fb_we === 1'b1 && fb_addr == 15'd5000) hit = 1'b1;
    end
    check_eq("mid_reach_5000", hit, 1);
    reset = 1'b1;
    $display("reset asserted during sweep at cycle %0d", cyc);
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_we_after_reset", fb_we, 0);
    check_eq("mid_busy_after_reset", busy, 0);
    base  = wr_addr_q.size();
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_ready_after_reset", plot_ready, 1);
    tick(1);
    send_plot(3, 4, 6, 1'b0, 0, acc);
    tick(4);
    check_eq("mid_new_plot_count", wr_addr_q.size(), base + 1);
    if (wr_addr_q.size() == base + 1) begin
      check_eq("mid_new_plot_addr", wr_addr_q[base], 643);
      check_eq("mid_new_plot_data", wr_data_q[base], 6);
    end

    // Plot and clear in the same cycle: the plot lands, then gets overwritten
    clear_log();
    send_plot(10, 10, 7, 1'b1, 0, acc0);
    wait_ready(busy_low, ready_cyc, n_wr);
    check_eq("same_busy_low_cycles", busy_low, 0);
    check_eq("same_writes_at_ready", n_wr, 1 + FB_WORDS);
    if (wr_addr_q.size() >= 1 + FB_WORDS) begin
      check_eq("same_plot_addr", wr_addr_q[0], 1610);
      check_eq("same_plot_data", wr_data_q[0], 7);
      check_eq("same_overwrite_addr", wr_addr_q[1+1610], 1610);
      check_eq("same_overwrite_data", wr_data_q[1+1610], 0);
    end
    check_eq("same_sweep_errors", sweep_errors(1, 0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_write_port.md
Name: pixel_write_port

Overview:
- Responder end of the game's pixel-plot interface: the game datapath issues (x, y, colour, plot) writes; this block accepts them with a valid/ready handshake.
- Buffers plots in a small FIFO, converts (x, y) to a linear 160x120 framebuffer address and drives the framebuffer RAM write port.
- Supports a full-screen clear that sweeps every address with a given colour, replacing per-frame erase loops in the datapath.

Parameters:
- H_RES, 160, horizontal pixels; valid x is 0..H_RES-1
- V_RES, 120, vertical pixels; valid y is 0..V_RES-1
- COLOUR_W, 3, colour bits per pixel (1 bit per channel)
- FIFO_DEPTH, 4, plot buffer entries (power of 2)
- ADDR_W, 15, framebuffer address width (covers 19200 words)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- plot_x  in  8  pixel column
- plot_y  in  8  pixel row
- plot_colour  in  COLOUR_W  pixel colour
- plot_valid  in  1  plot request valid
- plot_ready  out  1  block can accept a plot this cycle
- clear_req  in  1  one-cycle request to clear the screen
- clear_colour  in  COLOUR_W  fill colour, sampled on the cycle clear_req is accepted
- busy  out  1  FIFO non-empty, clear pending, or clear in progress
- fb_addr  out  ADDR_W  framebuffer write address
- fb_data  out  COLOUR_W  framebuffer write data
- fb_we  out  1  framebuffer write enable
- drop_count  out  8  saturating count of out-of-range plots

Behaviour:
- Reset (sync, active-high) forces:
  - state IDLE and FIFO empty
  - plot_ready=0 during the reset cycle, then 1 in the first cycle after reset
  - busy=0, fb_we=0, fb_addr=0, fb_data=0, drop_count=0
  - any clear pending or in progress is cleared
- Reset mid-clear or with a non-empty FIFO discards all pending work; no fb_we in the cycle after reset.
- Handshake:
  - A plot is accepted on a rising edge where plot_valid && plot_ready.
  - plot_ready = !fifo_full && !clear_pending && state != CLEAR.
  - x, y and colour must stay stable while valid is high and ready is low.
- Write stage:
  - When the FIFO is non-empty in IDLE, pop one entry per cycle.
  - fb_* outputs are registered, so a plot accepted at edge N into an empty FIFO produces fb_we=1 in the cycle after edge N+1 (2-cycle latency).
  - Back-to-back accepts produce one write per cycle. FIFO full only when a pop is blocked, which never happens in IDLE.
- Address arithmetic:
  - fb_addr = y*160 + x, computed as (y<<7)+(y<<5)+x.
  - Unsigned, ADDR_W bits, no truncation for in-range inputs; maximum value is 19199.
- Out-of-range plots (x>=H_RES or y>=V_RES):
  - accepted and popped normally, but the pop gives fb_we=0
  - drop_count increments by 1 and saturates at 255
- Clear:
  - clear_req is accepted when state is IDLE and no clear is pending. It sets clear_pending and latches clear_colour.
  - clear_req in any other state is ignored.
  - The FIFO drains first, then state moves to CLEAR.
  - In CLEAR: fb_we=1, fb_data=latched colour, fb_addr steps 0, 1, ..., 19199, one address per cycle (19200 write cycles).
  - After address 19199 is written, return to IDLE and drop clear_pending. plot_ready rises the next cycle.
- Simultaneous plot accept and clear_req in the same cycle: the plot enters the FIFO and is written before the sweep, so the clear overwrites it.
- busy = fifo_nonempty || clear_pending || state==CLEAR || fb_we.
- FSM states:
  - IDLE: drain FIFO; move to CLEAR when clear_pending && FIFO empty && no write in flight.
  - CLEAR: sweep addresses; return to IDLE on the last address.
- fb_we is never asserted for two different sources in one cycle.

Decomposition:
- Shared package (pixel_pkg): H_RES, V_RES, COLOUR_W, ADDR_W, the state encoding (IDLE, CLEAR), and an address helper function xy_to_addr.
- Sub-module plot_fifo: synchronous FIFO, FIFO_DEPTH x (8+8+COLOUR_W). Provides push, pop, full, empty; a push and pop in the same cycle is allowed.

Test Plan:
- Reset then single plot x=5, y=2, colour=3'b101 → exactly one fb_we pulse, 2 cycles after accept, with fb_addr=325 and fb_data=5; busy returns to 0.
- 8 consecutive plots with valid held high, x=0..7 at y=119 → 8 writes on consecutive cycles, addresses 19040..19047, plot_ready never drops.
- Plot x=160, y=0 then x=0, y=120 → no fb_we for either, drop_count=2. Then 300 out-of-range plots → drop_count saturates at 255.
- clear_req with clear_colour=3'b010 while 3 plots are queued → the 3 plot writes occur first, then 19200 writes with data 2 and addresses 0..19199. plot_ready stays low from the clear_req accept until the cycle after address 19199; busy stays high throughout.
- Assert reset at sweep address 5000 → next cycle fb_we=0 and busy=0; the cycle after that plot_ready=1 and a new plot is written normally.
- Plot accept and clear_req in the same cycle (x=10, y=10, colour 7; clear colour 0) → write to addr 1610 with data 7, followed by a full clear that writes 0 to addr 1610.
